logic_issue_unit: RTL and testbench



---
 rtl/logic_issue_unit_if.sv | 34 +++
 rtl/logic_issue_unit.sv | 148 ++++++++++++++
 tb/tb_logic_issue_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/logic_issue_unit_if.sv
// Bundled handshake and logic-unit signals between the issue stage, the
// logic_issue_unit front end and the external combinational logic unit.
interface logic_issue_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [5:0]       in_funct;
    logic [WIDTH-1:0] lu_a;
    logic [WIDTH-1:0] lu_b;
    logic [3:0]       lu_opcode;
    logic [WIDTH-1:0] lu_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] err_count;

    modport slave (
        input  in_valid, in_a, in_b, in_funct, lu_out, res_ready,
        output in_ready, lu_a, lu_b, lu_opcode, res_valid, res_data, res_err,
               op_count, err_count
    );

    modport master (
        output in_valid, in_a, in_b, in_funct, lu_out, res_ready,
        input  in_ready, lu_a, lu_b, lu_opcode, res_valid, res_data, res_err,
               op_count, err_count
    );
endinterface

// File: rtl/logic_issue_unit.sv
// Registered, flow-controlled front end for the 4-bit-opcode logic unit:
// accepts funct-tagged operand pairs, drives the unit, returns its result.
module logic_issue_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    logic_issue_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns {illegal, opcode}; illegal functs map to the all-zero opcode.
    function automatic logic [4:0] encode_funct(input logic [5:0] funct);
        logic [4:0] enc;
        case (funct)
            6'h24:   enc = 5'b0_0100;
            6'h25:   enc = 5'b0_0101;
            6'h26:   enc = 5'b0_0110;
            6'h27:   enc = 5'b0_0111;
            default: enc = 5'b1_0000;
        endcase
        return enc;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic             accept_s;
    logic             complete_s;
    logic [4:0]       enc_s;
    logic             in_ready_r;
    logic [WIDTH-1:0] lu_a_r;
    logic [WIDTH-1:0] lu_b_r;
    logic [3:0]       lu_opcode_r;
    logic             err_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] res_data_r;
    logic             res_err_r;
    logic [CNT_W-1:0] op_count_r;
    logic [CNT_W-1:0] err_count_r;

    // Next-state decode and handshake strobes.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        complete_s   = 1'b0;
        enc_s        = encode_funct(bus.in_funct);
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    next_state_s = ISSUE;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                next_state_s = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) begin
                    next_state_s = IDLE;
                    complete_s   = 1'b1;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register; in_ready is registered from the next state so it
    // depends on state alone and is high straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == IDLE);
        end
    end

    // Operand/opcode registers toward the logic unit, loaded only on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lu_a_r      <= {WIDTH{1'b0}};
            lu_b_r      <= {WIDTH{1'b0}};
            lu_opcode_r <= 4'b0000;
            err_r       <= 1'b0;
        end else if (accept_s) begin
            lu_a_r      <= bus.in_a;
            lu_b_r      <= bus.in_b;
            lu_opcode_r <= enc_s[3:0];
            err_r       <= enc_s[4];
        end
    end

    // Result capture on ISSUE, held until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_r <= 1'b0;
            res_data_r  <= {WIDTH{1'b0}};
            res_err_r   <= 1'b0;
        end else if (state_r == ISSUE) begin
            res_valid_r <= 1'b1;
            res_data_r  <= err_r ? {WIDTH{1'b0}} : bus.lu_out;
            res_err_r   <= err_r;
        end else if (complete_s) begin
            res_valid_r <= 1'b0;
        end
    end

    // Saturating completion counters, updated on the result handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count_r  <= {CNT_W{1'b0}};
            err_count_r <= {CNT_W{1'b0}};
        end else if (complete_s) begin
            if (!err_r) begin
                if (op_count_r != CNT_MAX) begin
                    op_count_r <= op_count_r + CNT_ONE;
                end
            end else if (err_count_r != CNT_MAX) begin
                err_count_r <= err_count_r + CNT_ONE;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.lu_a      = lu_a_r;
    assign bus.lu_b      = lu_b_r;
    assign bus.lu_opcode = lu_opcode_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_err   = res_err_r;
    assign bus.op_count  = op_count_r;
    assign bus.err_count = err_count_r;
endmodule

// File: tb/tb_logic_issue_unit.sv
// Self-checking bench for logic_issue_unit: vector table plus hand-written
// backpressure, mid-transaction reset and counter saturation sequences.
module tb_logic_issue_unit;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  funct;
        logic [3:0]  op;
        logic [31:0] data;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    exp_t sbq[$];
    vec_t vecs[8];
    int   sat_exp[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic_issue_unit_if #(.WIDTH(32), .CNT_W(16)) bus ();
    logic_issue_unit_if #(.WIDTH(32), .CNT_W(2))  sbus ();

    logic_issue_unit #(.WIDTH(32), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
    logic_issue_unit #(.WIDTH(32), .CNT_W(2))  dut_sat (.clk(clk), .reset(reset), .bus(sbus));

    // Reference behaviour of the external combinational logic unit.
    function automatic logic [31:0] lu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
        case (op)
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return a ^ b;
            4'b0111: return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    assign bus.lu_out     = lu_model(bus.lu_a, bus.lu_b, bus.lu_opcode);
    assign sbus.lu_out    = lu_model(sbus.lu_a, sbus.lu_b, sbus.lu_opcode);
    assign sbus.in_valid  = bus.in_valid;
    assign sbus.in_a      = bus.in_a;
    assign sbus.in_b      = bus.in_b;
    assign sbus.in_funct  = bus.in_funct;
    assign sbus.res_ready = bus.res_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard: a result handshake about to complete pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got 0x%08h expected no result", bus.res_data);
            end else begin
                e = sbq.pop_front();
                check("res_data", bus.res_data, e.data);
                check("res_err", 32'(bus.res_err), 32'(e.err));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                        input logic [3:0] op, input logic [31:0] data, input logic err,
                        output int acc_cyc);
        logic acc;
        exp_t e;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_funct = f;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_total++;
            $display("FAIL accept_timeout: got no accept expected accept within 40 cycles");
        end else begin
            e.data = data;
            e.err  = err;
            sbq.push_back(e);
            check("lu_opcode", 32'(bus.lu_opcode), 32'(op));
            check("lu_a", bus.lu_a, a);
            check("lu_b", bus.lu_b, b);
        end
        acc_cyc = cyc;
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (sbq.size() != 0 && i < 50) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (sbq.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        int t_prev;
        int t_now;
        logic [31:0] held;
        vecs[0] = '{32'hF0F0F0F0, 32'hFF00FF00, 6'h24, 4'b0100, 32'hF000F000, 1'b0};
        vecs[1] = '{32'hF0F0F0F0, 32'hFF00FF00, 6'h25, 4'b0101, 32'hFFF0FFF0, 1'b0};
        vecs[2] = '{32'hF0F0F0F0, 32'hFF00FF00, 6'h26, 4'b0110, 32'h0FF00FF0, 1'b0};
        vecs[3] = '{32'hF0F0F0F0, 32'hFF00FF00, 6'h27, 4'b0111, 32'h000F000F, 1'b0};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 6'h20, 4'b0000, 32'h00000000, 1'b1};
        vecs[5] = '{32'h12345678, 32'h0F0F0F0F, 6'h24, 4'b0100, 32'h02040608, 1'b0};
        vecs[6] = '{32'hAAAAAAAA, 32'h55555555, 6'h3F, 4'b0000, 32'h00000000, 1'b1};
        vecs[7] = '{32'hAAAAAAAA, 32'h55555555, 6'h27, 4'b0111, 32'h00000000, 1'b0};
        sat_exp = '{1, 2, 3, 3, 3};

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'h0;
        bus.in_b      = 32'h0;
        bus.in_funct  = 6'h0;
        bus.res_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_lu_opcode", 32'(bus.lu_opcode), 32'd0);
        check("rst_op_count", 32'(bus.op_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Table: back-to-back requests with in_valid held and res_ready high.
        bus.res_ready = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].funct, vecs[i].op, vecs[i].data, vecs[i].err, t_now);
            if (i > 0) check("accept_spacing", 32'(t_now - t_prev), 32'd3);
            t_prev = t_now;
        end
        bus.in_valid = 1'b0;
        wait_drain();
        check("table_op_count", 32'(bus.op_count), 32'd6);
        check("table_err_count", 32'(bus.err_count), 32'd2);

        // Backpressure: result held 10 cycles while new requests are offered.
        bus.res_ready = 1'b0;
        send(32'hA5A5A5A5, 32'h0F0F0F0F, 6'h26, 4'b0110, 32'hAAAAAAAA, 1'b0, t_now);
        bus.in_valid = 1'b0;
        check("latency_k", 32'(bus.res_valid), 32'd0);
        @(posedge clk);
        #1;
        check("latency_k1", 32'(bus.res_valid), 32'd1);
        check("latency_data", bus.res_data, 32'hAAAAAAAA);
        for (int i = 0; i < 10; i++) begin
            held = $urandom();
            bus.in_valid = i[0];
            bus.in_a     = held;
            bus.in_funct = 6'h24;
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_data", bus.res_data, 32'hAAAAAAAA);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_lu_a", bus.lu_a, 32'hA5A5A5A5);
            check("hold_lu_opcode", 32'(bus.lu_opcode), 32'd6);
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", 32'(bus.res_valid), 32'd0);
        check("release_consumed", 32'(sbq.size()), 32'd0);
        check("release_op_count", 32'(bus.op_count), 32'd7);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);

        // Partial-cycle reset while a result is held.
        bus.res_ready = 1'b0;
        send(32'h0000FFFF, 32'h00FF00FF, 6'h25, 4'b0101, 32'h00FFFFFF, 1'b0, t_now);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_res_data", bus.res_data, 32'h0);
        check("mid_rst_lu_a", bus.lu_a, 32'h0);
        check("mid_rst_lu_b", bus.lu_b, 32'h0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_op_count", 32'(bus.op_count), 32'd0);
        check("mid_rst_err_count", 32'(bus.err_count), 32'd0);
        sbq.delete();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        send(32'h0F0F0F0F, 32'h33333333, 6'h24, 4'b0100, 32'h03030303, 1'b0, t_now);
        bus.in_valid = 1'b0;
        wait_drain();
        check("post_rst_op_count", 32'(bus.op_count), 32'd1);

        // Saturation of the 2-bit counter instance.
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(32'h12345678 + 32'(i), 32'hFFFF0000, 6'h24, 4'b0100, 32'h12340000, 1'b0, t_now);
            bus.in_valid = 1'b0;
            wait_drain();
            check("sat_op_count", 32'(sbus.op_count), 32'(sat_exp[i]));
            check("wide_op_count", 32'(bus.op_count), 32'(i + 1));
        end
        check("sat_err_count", 32'(sbus.err_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
